binary_entry_printer: RTL

//  Collects a fixed-width binary word typed over the UART link as ASCII '0'/'1' characters.

---
 rtl/binary_entry_pkg.sv | 28 ++
 rtl/binary_entry_printer_tx.sv | 36 +++
 rtl/binary_entry_printer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/binary_entry_pkg.sv
// Shared types, ASCII constants and helpers for the binary entry printer.
// BIN_ENTRY_ECHO_EN adds the ECHO state used for per-digit echo.
package binary_entry_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        PFX0,
        PFX1,
        DIGIT,
        CR,
        LF
`ifdef BIN_ENTRY_ECHO_EN
        , ECHO
`endif
    } state_e;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_1   = 8'h31;
    localparam logic [7:0] CH_X   = 8'h78;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_ESC = 8'h1B;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (CH_0 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/binary_entry_printer_tx.sv
// Transmit handshake: issues one registered strobe per accepted request and
// holds off one cycle afterwards so the UART's busy flag can rise.
module tx_byte_issuer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic       ack_o,
    output logic [7:0] tx_data_o,
    output logic       new_tx_data_o
);

    logic       gap_q;
    logic       strobe_q;
    logic [7:0] tx_data_q;

    assign ack_o         = req_i && !tx_busy_i && !gap_q;
    assign tx_data_o     = tx_data_q;
    assign new_tx_data_o = strobe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q     <= 1'b0;
            strobe_q  <= 1'b0;
            tx_data_q <= '0;
        end else begin
            gap_q    <= ack_o;
            strobe_q <= ack_o;
            if (ack_o) begin
                tx_data_q <= byte_i;
            end
        end
    end

endmodule

// File: rtl/binary_entry_printer.sv
// Collects N_BITS ASCII '0'/'1' digits, reports the word and prints "0x<HEX>\r\n".
// Optional per-digit echo is enabled by defining BIN_ENTRY_ECHO_EN.
module binary_entry_printer
    import binary_entry_pkg::*;
#(
    parameter int N_BITS    = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              new_rx_data,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    output logic [N_BITS-1:0] word_out,
    output logic              word_valid,
    output logic              rx_dropped
);

    localparam int HEX_DIGITS = (N_BITS + 3) / 4;
    localparam int CW         = $clog2(N_BITS + 1);
    localparam int IW         = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_BITS-1:0]     sh_q, sh_d;
    logic [N_BITS-1:0]     word_q, word_d;
    logic                  wv_q, wv_d;
    logic                  drop_q, drop_d;
    logic [IW-1:0]         dig_q, dig_d;
    logic [4*HEX_DIGITS-1:0] pad;
    logic [3:0]            nib;
    logic                  req;
    logic [7:0]            tx_byte;
    logic                  ack;
    logic                  is_digit;
    logic [N_BITS-1:0]     bit_mask;
`ifdef BIN_ENTRY_ECHO_EN
    logic [7:0]            echo_q, echo_d;
`endif

    tx_byte_issuer u_tx (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .byte_i       (tx_byte),
        .tx_busy_i    (tx_busy),
        .ack_o        (ack),
        .tx_data_o    (tx_data),
        .new_tx_data_o(new_tx_data)
    );

    assign word_out   = word_q;
    assign word_valid = wv_q;
    assign rx_dropped = drop_q;
    assign is_digit   = (rx_data == CH_0) || (rx_data == CH_1);
    assign bit_mask   = N_BITS'(1) << cnt_q;

    always_comb begin
        pad = '0;
        pad[N_BITS-1:0] = word_q;
        nib = 4'(pad >> {dig_q, 2'b00});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            wv_q    <= 1'b0;
            drop_q  <= 1'b0;
            dig_q   <= '0;
`ifdef BIN_ENTRY_ECHO_EN
            echo_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            wv_q    <= wv_d;
            drop_q  <= drop_d;
            dig_q   <= dig_d;
`ifdef BIN_ENTRY_ECHO_EN
            echo_q  <= echo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        word_d  = word_q;
        wv_d    = 1'b0;
        drop_d  = 1'b0;
        dig_d   = dig_q;
        req     = 1'b0;
        tx_byte = CH_0;
`ifdef BIN_ENTRY_ECHO_EN
        echo_d  = echo_q;
`endif
        if (state_q != COLLECT) begin
            drop_d = new_rx_data;
        end
        case (state_q)
            COLLECT: begin
                // Completion is checked first so a full count always drains before new input.
                if (cnt_q == CW'(N_BITS)) begin
                    word_d  = sh_q;
                    wv_d    = 1'b1;
                    cnt_d   = '0;
                    sh_d    = '0;
                    dig_d   = IW'(HEX_DIGITS - 1);
                    state_d = PFX0;
                end else if (new_rx_data) begin
                    if (is_digit) begin
                        if (LSB_FIRST != 0) begin
                            sh_d = (sh_q & ~bit_mask) | (rx_data[0] ? bit_mask : '0);
                        end else begin
                            sh_d = (sh_q << 1) | N_BITS'(rx_data[0]);
                        end
                        cnt_d = cnt_q + CW'(1);
`ifdef BIN_ENTRY_ECHO_EN
                        echo_d  = rx_data;
                        state_d = ECHO;
`endif
                    end else if (rx_data == CH_ESC) begin
                        cnt_d = '0;
                        sh_d  = '0;
                    end
                end
            end
`ifdef BIN_ENTRY_ECHO_EN
            ECHO: begin
                req     = 1'b1;
                tx_byte = echo_q;
                if (ack) state_d = COLLECT;
            end
`endif
            PFX0: begin
                req     = 1'b1;
                tx_byte = CH_0;
                if (ack) state_d = PFX1;
            end
            PFX1: begin
                req     = 1'b1;
                tx_byte = CH_X;
                if (ack) state_d = DIGIT;
            end
            DIGIT: begin
                req     = 1'b1;
                tx_byte = nib2ascii(nib);
                if (ack) begin
                    if (dig_q == '0) state_d = CR;
                    else             dig_d   = dig_q - IW'(1);
                end
            end
            CR: begin
                req     = 1'b1;
                tx_byte = CH_CR;
                if (ack) state_d = LF;
            end
            LF: begin
                req     = 1'b1;
                tx_byte = CH_LF;
                if (ack) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

endmodule
